// File: rtl/usb3_ep0in_reader_pkg.sv
// Shared constants for the EP0 IN reader: FSM encoding, RAM read latency and
// the byte-enable rule for the final beat of a control-IN data stage.
package usb3_ep0in_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int RD_LATENCY = 2;
  localparam int BE_W       = 4;
  localparam int MAX_BYTES  = 64;

  // A partial last word keeps only the low len[1:0] bytes; a multiple of four is a full word.
  function automatic logic [BE_W-1:0] lastBe(input logic [1:0] lenLo);
    logic [BE_W-1:0] be;
    case (lenLo)
      2'b01:   be = 4'b0001;
      2'b10:   be = 4'b0011;
      2'b11:   be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/usb3_ep0in_reader_if.sv
// Control, RAM-read and output-stream signals of the EP0 IN reader.
// master = reader side, slave = controller / RAM / packet-builder side.
interface usb3_ep0in_reader_if
  import usb3_ep0in_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic              start;
  logic [6:0]        len_bytes;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_adr;
  logic [DATA_W-1:0] rd_dat_r;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [BE_W-1:0]   out_be;
  logic              out_last;

  modport master (
    input  start, len_bytes, abort, rd_dat_r, out_ready,
    output busy, done, rd_adr, out_valid, out_data, out_be, out_last
  );

  modport slave (
    output start, len_bytes, abort, rd_dat_r, out_ready,
    input  busy, done, rd_adr, out_valid, out_data, out_be, out_last
  );

endinterface

// File: rtl/usb3_ep0in_reader_fifo.sv
// Synchronous output FIFO of {last, be, data} beats; the occupancy count feeds
// the reader's read-credit calculation.
module usb3_ep0in_fifo
  import usb3_ep0in_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    doPop   = pop_i && (count_q != '0);
    doPush  = push_i && (count_q != CNT_W'(DEPTH));
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flush only rewinds the pointers; stale entries are never exposed since valid_o follows count.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  assign popData_o = mem_q[rdPtr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/usb3_ep0in_reader.sv
// EP0 IN data-stage reader: issues RAM reads ahead, re-times them into a valid/ready stream.
// Optional feature: define USB3_EP0IN_READER_ZLP_EN to emit a zero-length beat for len_bytes=0.
module usb3_ep0in_reader
  import usb3_ep0in_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  usb3_ep0in_reader_if.master rdr
);

  localparam int ENTRY_W = DATA_W + BE_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W-1:0] lastWord_q, lastWord_d;
  logic [1:0]        lenLo_q, lenLo_d;
  logic              done_q, done_d;

  logic [RD_LATENCY-1:0]           pVld_q, pLast_q, pZero_q;
  logic [RD_LATENCY-1:0][BE_W-1:0] pBe_q;

  logic [6:0]         lenClamp;
  logic [4:0]         words;
  logic [7:0]         inFlight;
  logic               credit;
  logic               issue, issueLast, inject;
  logic [BE_W-1:0]    newBe;
  logic               pipeEmpty, lastHandshake;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoValid, fifoPop;
  logic [ENTRY_W-1:0] fifoIn, fifoOut;
  logic               fLast;
  logic [BE_W-1:0]    fBe;
  logic [DATA_W-1:0]  fData;

  // A read may issue only if it is guaranteed a FIFO slot when its data returns.
  always_comb begin
    inFlight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inFlight = inFlight + 8'(pVld_q[i]);
    end
    credit   = (inFlight + 8'(fifoCount)) < 8'(FIFO_DEPTH);
    lenClamp = (rdr.len_bytes > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : rdr.len_bytes;
    words    = 5'((lenClamp + 7'd3) >> 2);
  end

  assign pipeEmpty     = (pVld_q == '0);
  assign fifoPop       = fifoValid && rdr.out_ready;
  assign lastHandshake = fifoPop && fLast;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    lastWord_d = lastWord_q;
    lenLo_d    = lenLo_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issueLast  = 1'b0;
    inject     = 1'b0;
    if (rdr.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdr.start) begin
            adr_d      = '0;
            lenLo_d    = lenClamp[1:0];
            lastWord_d = ADDR_W'(words - 5'd1);
            if (words == 5'd0) begin
`ifdef USB3_EP0IN_READER_ZLP_EN
              inject  = 1'b1;
              state_d = ST_DRAIN;
`else
              done_d  = 1'b1;
              state_d = ST_DRAIN;
`endif
            end else begin
              state_d = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (credit) begin
            issue = 1'b1;
            // The counter parks on the final address so it never passes word 15.
            if (adr_q == lastWord_q) begin
              issueLast = 1'b1;
              state_d   = ST_DRAIN;
            end else begin
              adr_d = adr_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (lastHandshake) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (pipeEmpty && !fifoValid) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      lastWord_q <= '0;
      lenLo_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      lastWord_q <= lastWord_d;
      lenLo_q    <= lenLo_d;
      done_q     <= done_d;
    end
  end

  assign newBe = inject ? '0 : (issueLast ? lastBe(lenLo_q) : '1);

  // Tags travel alongside each read so they meet their data when the RAM answers.
  always_ff @(posedge clk) begin
    if (reset || rdr.abort) begin
      pVld_q  <= '0;
      pLast_q <= '0;
      pZero_q <= '0;
      pBe_q   <= '0;
    end else begin
      pVld_q  <= {pVld_q[RD_LATENCY-2:0], issue | inject};
      pLast_q <= {pLast_q[RD_LATENCY-2:0], issueLast | inject};
      pZero_q <= {pZero_q[RD_LATENCY-2:0], inject};
      pBe_q   <= {pBe_q[RD_LATENCY-2:0], newBe};
    end
  end

  assign fifoIn = {pLast_q[RD_LATENCY-1], pBe_q[RD_LATENCY-1],
                   pZero_q[RD_LATENCY-1] ? {DATA_W{1'b0}} : rdr.rd_dat_r};

  usb3_ep0in_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (rdr.abort),
    .push_i     (pVld_q[RD_LATENCY-1]),
    .pushData_i (fifoIn),
    .pop_i      (fifoPop),
    .popData_o  (fifoOut),
    .valid_o    (fifoValid),
    .count_o    (fifoCount)
  );

  assign {fLast, fBe, fData} = fifoOut;

  assign rdr.busy      = (state_q != ST_IDLE);
  assign rdr.done      = done_q;
  assign rdr.rd_adr    = adr_q;
  assign rdr.out_valid = fifoValid;
  assign rdr.out_data  = fifoValid ? fData : '0;
  assign rdr.out_be    = fifoValid ? fBe : '0;
  assign rdr.out_last  = fifoValid && fLast;

endmodule

// File: doc/usb3_ep0in_reader.md
# usb3_ep0in_reader

Streams a control-IN data stage out of the 16x32b EP0 IN buffer RAM, which has 2-cycle read latency. Sits directly downstream of the buffer. Generates RAM read addresses and re-times the returned words into a valid/ready stream with per-beat byte enables and a last flag, feeding the protocol-layer packet builder. Absorbs backpressure with a small output FIFO, so reads issue ahead without losing data.

## Interface
- ADDR_W, 4, RAM word-address width (16 words)
- DATA_W, 32, RAM/stream data width
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ read latency + 2
- clk  in  1  single clock domain
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begin transfer (ignored while busy)
- len_bytes  in  7  transfer length in bytes, sampled with start; values >64 clamp to 64
- abort  in  1  one-cycle pulse; cancel transfer, flush
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion (not on abort)
- rd_adr  out  ADDR_W  RAM read address
- rd_dat_r  in  DATA_W  RAM read data, valid 2 cycles after rd_adr
- out_valid  out  1  stream beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_W  beat data, byte 0 in bits [7:0]
- out_be  out  4  byte enables for the beat
- out_last  out  1  final beat of transfer

## Operation
- States: IDLE, READ (issuing addresses), DRAIN (all reads issued, emptying FIFO and pipe).
- IDLE + start: latch len = min(len_bytes,64); words = (len+3)>>2 (5-bit); address counter = 0; go to READ.
- READ: issue one address per cycle while credits allow. Credits: in-flight reads + FIFO occupancy < FIFO_DEPTH. A 2-stage valid shift register tracks in-flight reads. After the last address is issued, go to DRAIN.
- Returning data writes the FIFO together with tag bits last and be.
- Non-last beats: be=1111. Last beat: be from len[1:0]: 00→1111, 01→0001, 10→0011, 11→0111.
- DRAIN: when the last beat handshakes (out_valid & out_ready & out_last), pulse done in the next cycle and return to IDLE.
- abort (any state): go to IDLE next cycle. Flush FIFO, clear in-flight valids, no done.
- abort and start in the same cycle: abort wins, start is ignored.
- start while busy: ignored.
- rd_adr holds its last value when not issuing.
- The address counter never exceeds 15; 64 bytes uses words 0..15 exactly.
- reset: same as abort, plus all outputs reset to values below.

## Timing
- Reset values: busy=0, done=0, rd_adr=0, out_valid=0, out_data=0, out_be=0, out_last=0.
- start sampled at the edge ending cycle 0:
  - busy=1 and rd_adr=0 during cycle 1.
  - RAM data arrives in cycle 3.
  - out_valid=1 in cycle 4, so first-beat latency is 4 cycles.
- With out_ready held high: one beat per cycle, no bubbles after the first.
- out_valid/out_data/out_be/out_last stay stable while out_valid & !out_ready.
- done pulses in the cycle after the last handshake; busy falls in the same cycle.
- A new start is accepted in the done cycle or later.

## Configuration
- USB3_EP0IN_READER_ZLP_EN
  - Defined: len_bytes=0 produces exactly one beat with out_be=0000, out_last=1, out_data=0, and no RAM read, then done.
  - Undefined: len_bytes=0 produces no beats; done pulses 1 cycle after start, and busy=1 for that one cycle.

## Structure
- Package usb3_ep0in_pkg:
  - state encoding (IDLE/READ/DRAIN)
  - RD_LATENCY=2
  - last-beat byte-enable function of len[1:0]
- Sub-module usb3_ep0in_fifo: synchronous FIFO_DEPTH-entry FIFO of {last, be, data} with an occupancy count output used for credits.

## Test plan
- len=64, out_ready=1: addresses 0..15 in consecutive cycles; 16 beats in cycles 4..19, all be=1111, last on beat 16; done in cycle 20.
- len=5: 2 beats, words 0 and 1; beat 2 has be=0001 and out_last=1; done one cycle after it.
- len=64 with out_ready toggled 1,0,0,1 repeatedly: no lost or duplicated words, data order 0..15 preserved, rd_adr stalls whenever FIFO plus in-flight reaches 4.
- abort in cycle 6 of a len=64 transfer: out_valid=0 from cycle 7, no done, busy=0; a new start with len=8 then yields exactly 2 correct beats.
- len=0: ZLP_EN defined gives one beat with be=0000, last=1; undefined gives zero beats and done in cycle 1.
- len_bytes=100: clamped to 64, giving 16 beats and final be=1111.
